arb8_rr_ctrl: RTL and testbench
===============================

Name: arb8_rr_ctrl

Overview:
- Sequential 8-requester arbiter built around an 8-to-3 priority-encode function.
- Shares one resource among 8 requesters:
  - samples the request lines,
  - selects one owner by fixed or rotating priority,
  - holds the grant until the owner releases it or a hold limit expires.
- Sits between requester blocks and any shared single-port datapath (bus, memory port, UART TX).

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset; asserts immediately, releases synchronously to clk.
- req, input, 8, request vector; bit i = requester i wants the resource; level-sensitive.
- mode, input, 1, 0 = fixed priority (index 7 highest), 1 = round-robin; sampled only in IDLE.
- gnt, output, 8, one-hot grant, registered; all-zero when no owner.
- gnt_idx, output, 3, binary index of the owner, registered; 0 when gnt_valid=0.
- gnt_valid, output, 1, high while gnt is nonzero.
- hold_timeout, output, 1, one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset values:
  - gnt=0, gnt_idx=0, gnt_valid=0, hold_timeout=0.
  - State=IDLE, hold_cnt=0, last_owner=0.
- Reset assertion mid-grant drops gnt in the same cycle (asynchronous).
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at a rising edge, the winner is computed combinationally.
  - Next state is GRANT; gnt/gnt_idx/gnt_valid register the winner on that edge.
  - Grant latency: 1 cycle from req sampled to gnt visible.
  - req == 0 stays in IDLE.
- Winner selection, fixed mode (mode=0): highest set index wins, the same ordering as the priority encoder.
- Winner selection, round-robin mode (mode=1):
  - Search descending from (last_owner-1) mod 8, wrapping 0 -> 7; last_owner has the lowest priority.
  - After reset last_owner=0, so the search starts at 7 and the first grant equals fixed mode.
- GRANT:
  - hold_cnt increments each cycle while granted; it is 1 in the first grant cycle.
  - If req[gnt_idx]=0: release. gnt goes to 0 on the next edge, last_owner<=gnt_idx, state -> GAP.
  - Else if hold_cnt==MAX_HOLD: forced release. Same updates as a normal release, plus hold_timeout=1 for exactly that next cycle.
  - Else: hold the grant; all other req changes are ignored.
- GAP:
  - Exactly one idle cycle with gnt=0 (bus turnaround); hold_cnt<=0; then IDLE.
  - Minimum re-grant spacing is therefore 2 cycles after release.
- Simultaneous events:
  - Owner drops req on the same edge hold_cnt reaches MAX_HOLD: treat as a normal release, no hold_timeout.
  - A mode change during GRANT/GAP takes effect at the next IDLE arbitration.
- A timed-out owner in fixed mode can win again after GAP if it remains highest; this is intended. Round-robin guarantees rotation.
- gnt is always one-hot or zero; gnt_idx always matches the set bit.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - NUM_REQ=8 and IDX_W=3.
- One natural sub-module: arb8_pick.
  - Combinational: req[7:0], start[2:0], mode -> win_idx[2:0], win_valid.
  - Implements rotate-by-start, then 8-to-3 priority encode, then un-rotate.
- The top level contains the FSM, hold counter and last_owner register.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, then release -> gnt=0 during reset; first edge after release gives gnt=8'h80, gnt_idx=7, gnt_valid=1.
- Fixed priority: mode=0, req=8'b0010_0110 -> gnt_idx=5. Drop req[5] -> gnt=0 for 2 cycles (release + GAP), then gnt_idx=2.
- Round-robin rotation: mode=1, req=8'hFF, each owner drops req after 3 cycles then reasserts. Grant order is 7,6,5,4,3,2,1,0,7.
- Hold timeout: MAX_HOLD=16, mode=1, req=8'b1000_0001 held constant. Owner 7 is granted 16 cycles, then gnt drops with hold_timeout=1 for one cycle; after GAP, owner 0 is granted.
- Simultaneous release/timeout: the owner drops req on the cycle hold_cnt==MAX_HOLD -> hold_timeout stays 0, GAP occurs normally.
- Async reset mid-grant: pulse rst_n low while gnt_idx=3 -> gnt=0 and gnt_valid=0 within the reset pulse without waiting for a clock edge. After release, round-robin restarts from index 7.

Source files
------------

// File: rtl/arb8_rr_ctrl_pkg.sv
// Shared definitions for the 8-requester arbiter: FSM encodings, sizes and
// the 8-to-3 priority encoder used by the winner picker.
package arb8_rr_ctrl_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Highest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] prio_enc8(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb8_rr_ctrl_pick.sv
// Combinational winner picker. The request vector is rotated so that the
// highest-priority index lands on bit 7, priority-encoded, then the encoded
// index is rotated back. Fixed mode simply forces the top index to 7.
module arb8_pick
  import arb8_rr_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic               mode,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [IDX_W-1:0]   eff_start;
  logic [IDX_W-1:0]   src;
  logic [IDX_W-1:0]   enc;
  logic [NUM_REQ-1:0] rot;

  // Rotate so rot[7] = req[eff_start], rot[6] = req[eff_start-1], ...
  always_comb begin
    eff_start = mode ? start : IDX_W'(NUM_REQ - 1);
    src       = '0;
    rot       = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      src    = IDX_W'(j) + eff_start + 3'd1;
      rot[j] = req[src];
    end
    enc       = prio_enc8(rot);
    win_idx   = enc + eff_start + 3'd1;
    win_valid = |req;
  end

endmodule

// File: rtl/arb8_rr_ctrl.sv
// Sequential 8-requester arbiter: IDLE samples requests and registers a
// winner, GRANT holds it until release or hold limit, GAP inserts one
// turnaround cycle before the next arbitration.
module arb8_rr_ctrl
  import arb8_rr_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               hold_timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               hold_timeout_q, hold_timeout_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [IDX_W-1:0]   rr_start;

  // The previous owner gets the lowest priority: search starts just below it.
  assign rr_start = last_owner_q - 3'd1;

  arb8_pick u_pick (
    .req       (req),
    .start     (rr_start),
    .mode      (mode),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Next-state logic for the FSM, hold counter and registered outputs.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    last_owner_d   = last_owner_q;
    gnt_d          = gnt_q;
    gnt_idx_d      = gnt_idx_q;
    gnt_valid_d    = gnt_valid_q;
    hold_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = GRANT;
          gnt_d       = NUM_REQ'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        // Owner release takes precedence over the hold limit, so a drop on
        // the limit cycle is an ordinary release without a timeout pulse.
        if (!req[gnt_idx_q] || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
          state_d        = GAP;
          last_owner_d   = gnt_idx_q;
          gnt_d          = '0;
          gnt_idx_d      = '0;
          gnt_valid_d    = 1'b0;
          hold_timeout_d = req[gnt_idx_q];
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
      default: begin
        state_d     = IDLE;
        hold_cnt_d  = '0;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      last_owner_q   <= '0;
      gnt_q          <= '0;
      gnt_idx_q      <= '0;
      gnt_valid_q    <= 1'b0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      last_owner_q   <= last_owner_d;
      gnt_q          <= gnt_d;
      gnt_idx_q      <= gnt_idx_d;
      gnt_valid_q    <= gnt_valid_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_idx      = gnt_idx_q;
  assign gnt_valid    = gnt_valid_q;
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Scoreboard bench for arb8_rr_ctrl: stimulus pushes expected grants
// (owner, length, timeout flag, gap before it); a negedge monitor pops and
// checks each grant as the DUT presents it.
module tb_arb8_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_timeout;

  always #5 clk = ~clk;

  arb8_rr_ctrl #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .hold_timeout (hold_timeout)
  );

  // idx: owner; len: grant cycles (-1 = unchecked); to: timeout pulse
  // expected after it; gap: idle cycles before it (-1 = unchecked)
  typedef struct {
    int idx;
    int len;
    bit to;
    int gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic push(input int idx, input int len, input bit to, input int gap);
    exp_t e;
    e.idx = idx; e.len = len; e.to = to; e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: tracks grant boundaries and checks against the queue.
  bit   in_g = 1'b0;
  int   glen = 0;
  int   gap  = -1;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_g = 1'b0;
      gap  = -1;
    end else if (gnt_valid) begin
      if (!in_g) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", {29'd0, gnt_idx}, 32'hFFFF_FFFF);
          cur.idx = 0; cur.len = -1; cur.to = 1'b0; cur.gap = -1;
        end else begin
          cur = q.pop_front();
          if (cur.gap >= 0) chk("gap_len", gap, cur.gap);
        end
        in_g = 1'b1;
        glen = 0;
      end
      glen++;
      chk("gnt_onehot", {24'd0, gnt}, 32'(8'd1 << cur.idx));
      chk("gnt_idx", {29'd0, gnt_idx}, cur.idx);
      chk("timeout_in_grant", {31'd0, hold_timeout}, 0);
    end else begin
      chk("idle_gnt", {21'd0, gnt, gnt_idx}, 0);
      if (in_g) begin
        in_g = 1'b0;
        if (cur.len >= 0) chk("grant_len", glen, cur.len);
        chk("timeout_pulse", {31'd0, hold_timeout}, {31'd0, cur.to});
        gap = 1;
      end else if (gap >= 0) begin
        gap++;
        if (gap == 2) chk("timeout_one_cycle", {31'd0, hold_timeout}, 0);
      end
    end
  end

  initial begin
    // Reset with all requests asserted
    rst_n = 1'b0; req = 8'hFF; mode = 1'b0;
    cyc(3);
    chk("rst_gnt", {24'd0, gnt}, 0);
    chk("rst_idx", {29'd0, gnt_idx}, 0);
    chk("rst_valid", {31'd0, gnt_valid}, 0);
    chk("rst_timeout", {31'd0, hold_timeout}, 0);
    rst_n = 1'b1;
    push(7, 1, 1'b0, -1);
    cyc(1);
    chk("first_gnt", {24'd0, gnt}, 32'h80);
    chk("first_idx", {29'd0, gnt_idx}, 7);
    chk("first_valid", {31'd0, gnt_valid}, 1);
    req = 8'h00;
    cyc(3);

    // Fixed priority: 5 wins, then 2 after release + GAP
    push(5, 3, 1'b0, -1);
    push(2, 2, 1'b0, 2);
    req = 8'b0010_0110;
    cyc(3);
    req = 8'b0000_0110;
    cyc(4);
    req = 8'h00;
    cyc(3);

    // Round-robin rotation 7..0 then 7
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 9; k++) push((15 - k) % 8, 3, 1'b0, (k == 0) ? -1 : 2);
    req = 8'hFF;
    cyc(1);
    for (int k = 0; k < 9; k++) begin
      cyc(2);
      req = 8'hFF & ~(8'd1 << ((15 - k) % 8));
      cyc(1);
      req = (k == 8) ? 8'h00 : 8'hFF;
      if (k < 8) cyc(2);
    end
    cyc(3);

    // Hold timeout: 7 forced off after 16 cycles, then 0
    do_reset();
    mode = 1'b1;
    push(7, 16, 1'b1, -1);
    push(0, 2, 1'b0, 2);
    req = 8'b1000_0001;
    cyc(20);
    req = 8'h00;
    cyc(3);

    // Owner drops on the hold-limit cycle: normal release
    push(7, 16, 1'b0, -1);
    req = 8'h80;
    cyc(16);
    req = 8'h00;
    cyc(4);

    // Asynchronous reset mid-grant
    mode = 1'b0;
    push(3, -1, 1'b0, -1);
    req = 8'h08;
    cyc(1);
    chk("pre_rst_idx", {29'd0, gnt_idx}, 3);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", {24'd0, gnt}, 0);
    chk("async_valid", {31'd0, gnt_valid}, 0);
    chk("async_idx", {29'd0, gnt_idx}, 0);
    req = 8'hFF; mode = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    push(7, 1, 1'b0, -1);
    cyc(1);
    chk("rr_restart_gnt", {24'd0, gnt}, 32'h80);
    req = 8'h00;
    cyc(4);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
